// File: rtl/pc_redirect_if.sv
// Fetch-side bundle of the PC redirect unit: EX-stage resolve inputs, hazard stall,
// and the fetch PC / flush / pending-redirect outputs.
interface pc_redirect_if #(
  parameter int DATA_W = 32
);
  logic              stall_i;
  logic              ex_valid_i;
  logic              ex_branch_i;
  logic              ex_branch_ne_i;
  logic              ex_zero_i;
  logic              ex_jump_i;
  logic [DATA_W-1:0] ex_jump_target_i;
  logic [DATA_W-1:0] ex_pc_plus4_i;
  logic [DATA_W-1:0] ex_offset_sl2_i;
  logic [DATA_W-1:0] pc_o;
  logic [DATA_W-1:0] pc_plus4_o;
  logic              flush_o;
  logic              redirect_pending_o;
  logic [DATA_W-1:0] branch_target_o;

  modport master (
    output stall_i, ex_valid_i, ex_branch_i, ex_branch_ne_i, ex_zero_i,
           ex_jump_i, ex_jump_target_i, ex_pc_plus4_i, ex_offset_sl2_i,
    input  pc_o, pc_plus4_o, flush_o, redirect_pending_o, branch_target_o
  );

  modport slave (
    input  stall_i, ex_valid_i, ex_branch_i, ex_branch_ne_i, ex_zero_i,
           ex_jump_i, ex_jump_target_i, ex_pc_plus4_i, ex_offset_sl2_i,
    output pc_o, pc_plus4_o, flush_o, redirect_pending_o, branch_target_o
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch-PC register with beq/bne/j redirect resolution for the 5-stage MIPS pipeline.
// A redirect resolved under a hazard stall is parked in HOLD until the stall releases.
module pc_redirect_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input logic           clk_i,
  input logic           rst_i,
  pc_redirect_if.slave  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] add_wrap(
    input logic [DATA_W-1:0]        base,
    input logic signed [DATA_W-1:0] offs
  );
    return base + $unsigned(offs);
  endfunction

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return addr & ~DATA_W'(3);
  endfunction

  state_t                   state_p1, state_nxt;
  logic [DATA_W-1:0]        pc_p1, pc_nxt;
  logic [DATA_W-1:0]        target_p1, target_nxt;
  logic [DATA_W-1:0]        pc_plus4;
  logic signed [DATA_W-1:0] offset_s;
  logic [DATA_W-1:0]        br_target;
  logic [DATA_W-1:0]        jmp_target;
  logic [DATA_W-1:0]        target;
  logic                     br_taken;
  logic                     jmp;
  logic                     taken;
  logic                     flush;

  // Stage p0: EX-stage resolve, all combinational
  always_comb begin
    offset_s   = bus.ex_offset_sl2_i;
    br_target  = add_wrap(bus.ex_pc_plus4_i, offset_s);
    jmp_target = word_align(bus.ex_jump_target_i);
    br_taken   = bus.ex_valid_i & bus.ex_branch_i & (bus.ex_zero_i ^ bus.ex_branch_ne_i);
    jmp        = bus.ex_valid_i & bus.ex_jump_i;
    taken      = br_taken | jmp;
    target     = jmp ? jmp_target : br_target;
    pc_plus4   = add_wrap(pc_p1, DATA_W'(4));
  end

  always_comb begin
    state_nxt  = state_p1;
    pc_nxt     = pc_p1;
    target_nxt = target_p1;
    flush      = 1'b0;
    unique case (state_p1)
      RUN: begin
        if (taken && !bus.stall_i) begin
          pc_nxt = target;
          flush  = 1'b1;
        end else if (taken && bus.stall_i) begin
          target_nxt = target;
          state_nxt  = HOLD;
        end else if (!bus.stall_i) begin
          pc_nxt = pc_plus4;
        end
      end
      HOLD: begin
        // EX is frozen upstream while stalled, so its inputs are ignored here
        if (!bus.stall_i) begin
          pc_nxt    = target_p1;
          flush     = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Stage p1: fetch PC, held target and redirect state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p1  <= RUN;
      pc_p1     <= RESET_PC;
      target_p1 <= '0;
    end else begin
      state_p1  <= state_nxt;
      pc_p1     <= pc_nxt;
      target_p1 <= target_nxt;
    end
  end

  assign bus.pc_o               = pc_p1;
  assign bus.pc_plus4_o         = pc_plus4;
  assign bus.flush_o            = flush & ~rst_i;
  assign bus.redirect_pending_o = (state_p1 == HOLD);
  assign bus.branch_target_o    = target_p1;

endmodule
